pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline-stage register with a valid/ready handshake, a one-entry skid buffer and a synchronous flush. It generalises the fixed MEM/WB-style stage latch: any payload width, full-throughput back-pressure without a combinational ready path, and bubble insertion on flush. It sits between any two pipeline stages of the CPU, such as IF/ID, ID/EX, EX/MEM or MEM/WB, with the stage fields concatenated into one payload bus.

---
 rtl/pipe_stage_skid_if.sv | 23 ++
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 tb/tb_pipe_stage_skid.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for an elastic pipeline stage: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_skid_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // Traffic generator / consumer view
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Pipeline stage view
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: main + one-entry skid buffer, registered ready,
// synchronous flush with a saturating count of discarded entries.
module pipe_stage_skid #(
   parameter int unsigned         WIDTH  = 32,
   parameter logic [WIDTH-1:0]    BUBBLE = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   pipe_stage_skid_if.slave       bus,
   output logic [1:0]             occupancy,
   output logic [7:0]             drop_cnt
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Encoding equals the number of held entries, so occupancy is a direct register read.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   main_q, main_d;
   logic [WIDTH-1:0]   skid_q, skid_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic [SUM_W-1:0]   drop_sum;
   logic               in_fire, out_fire;

   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;

   // Next-state, payload movement and drop accounting
   always_comb begin
      state_d     = state_q;
      main_d      = main_q;
      skid_d      = skid_q;
      drop_d      = drop_q;
      drop_sum    = '0;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;

      if (flush) begin
         state_d  = EMPTY;
         main_d   = BUBBLE;
         skid_d   = BUBBLE;
         // out_fire implies at least one held entry, so this never underflows.
         drop_sum = SUM_W'(drop_q) + SUM_W'(state_q) + SUM_W'(in_fire) - SUM_W'(out_fire);
         drop_d   = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = bus.in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = bus.in_data;
               end else if (in_fire) begin
                  skid_d  = bus.in_data;
                  state_d = FULL;
               end else if (out_fire) begin
                  main_d  = BUBBLE;
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  skid_d  = BUBBLE;
                  state_d = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = BUBBLE;
               skid_d  = BUBBLE;
            end
         endcase
      end

      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         main_q      <= BUBBLE;
         skid_q      <= BUBBLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         drop_q      <= drop_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;
   assign occupancy     = 2'(state_q);
   assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: FIFO scoreboard plus a vector table and
// hand-written flush / saturation / async-reset sequences.
module tb_pipe_stage_skid;

   localparam int unsigned W   = 32;
   localparam logic [W-1:0] BUB = 32'h0;

   logic       clk;
   logic       reset;
   logic       flush;
   logic [1:0] occupancy;
   logic [7:0] drop_cnt;

   pipe_stage_skid_if #(.WIDTH(W)) bus ();

   pipe_stage_skid #(.WIDTH(W), .BUBBLE(BUB)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .bus       (bus.slave),
      .occupancy (occupancy),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         fl;
      logic [1:0]   occ;
      logic [7:0]   drop;
   } vec_t;

   logic [W-1:0] sbq[$];
   int           mdrop;
   int           checks;
   int           errors;
   vec_t         vecs[$];

   function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy,
                               input logic fl, input logic [1:0] occ, input logic [7:0] drop);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.occ = occ; v.drop = drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, update the scoreboard, check after the rising edge.
   task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      logic         inf;
      logic         outf;
      logic [W-1:0] exp;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      flush         = fl;
      inf  = iv & bus.in_ready;
      outf = bus.out_valid & ordy;
      if (outf) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got out_valid=1 data %h expected no output", bus.out_data);
         end else begin
            exp = sbq.pop_front();
            chk("out_data", bus.out_data, exp);
         end
      end
      if (fl) begin
         mdrop = mdrop + sbq.size() + int'(inf);
         if (mdrop > 255) mdrop = 255;
         sbq.delete();
      end else if (inf) begin
         sbq.push_back(d);
      end
      @(posedge clk);
      #1;
      chk("occupancy", W'(occupancy), W'(sbq.size()));
      chk("in_ready", W'(bus.in_ready), W'(sbq.size() != 2));
      chk("out_valid", W'(bus.out_valid), W'(sbq.size() != 0));
      chk("drop_cnt", W'(drop_cnt), W'(mdrop));
      if (sbq.size() == 0) chk("bubble", bus.out_data, BUB);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, W'(bus.in_ready), '0);
      chk({tag, "_out_valid"}, W'(bus.out_valid), '0);
      chk({tag, "_occupancy"}, W'(occupancy), '0);
      chk({tag, "_drop_cnt"}, W'(drop_cnt), '0);
      chk({tag, "_out_data"}, bus.out_data, BUB);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      mdrop         = 0;
      reset         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset values, then in_ready rises on the first edge after release
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_in_ready", W'(bus.in_ready), W'(1));
      chk("rel_out_valid", W'(bus.out_valid), '0);

      // Sustained stream 1..8, then drain
      for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // Back-pressure and flush vectors
      vecs.push_back(mk(1'b1, 32'hA0, 1'b1, 1'b0, 2'd1, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA1, 1'b1, 1'b0, 2'd1, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA2, 1'b0, 1'b0, 2'd2, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA3, 1'b0, 1'b0, 2'd2, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA3, 1'b0, 1'b0, 2'd2, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA3, 1'b1, 1'b0, 2'd1, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA3, 1'b1, 1'b0, 2'd1, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA4, 1'b1, 1'b0, 2'd1, 8'd0));
      vecs.push_back(mk(1'b1, 32'hA5, 1'b1, 1'b0, 2'd1, 8'd0));
      vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b0, 2'd0, 8'd0));
      // Flush when FULL: in_ready is low, so 0x33 is never accepted; two entries dropped
      vecs.push_back(mk(1'b1, 32'h11, 1'b0, 1'b0, 2'd1, 8'd0));
      vecs.push_back(mk(1'b1, 32'h22, 1'b0, 1'b0, 2'd2, 8'd0));
      vecs.push_back(mk(1'b1, 32'h33, 1'b0, 1'b1, 2'd0, 8'd2));
      vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b0, 2'd0, 8'd2));
      // Flush with concurrent out_fire: 0x44 delivered, count unchanged
      vecs.push_back(mk(1'b1, 32'h44, 1'b0, 1'b0, 2'd1, 8'd2));
      vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b1, 2'd0, 8'd2));
      // Flush in ONE with concurrent in_fire: held entry and incoming both dropped
      vecs.push_back(mk(1'b1, 32'h55, 1'b0, 1'b0, 2'd1, 8'd2));
      vecs.push_back(mk(1'b1, 32'h66, 1'b0, 1'b1, 2'd0, 8'd4));

      foreach (vecs[k]) begin
         step(vecs[k].iv, vecs[k].d, vecs[k].ordy, vecs[k].fl);
         chk($sformatf("vec%0d_occ", k), W'(occupancy), W'(vecs[k].occ));
         chk($sformatf("vec%0d_drop", k), W'(drop_cnt), W'(vecs[k].drop));
      end

      // drop_cnt saturation
      for (int i = 0; i < 130; i++) begin
         step(1'b1, W'(32'h1000 + 2 * i), 1'b0, 1'b0);
         step(1'b1, W'(32'h1001 + 2 * i), 1'b0, 1'b0);
         step(1'b0, '0, 1'b0, 1'b1);
      end
      chk("sat_255", W'(drop_cnt), W'(255));
      step(1'b1, 32'hBEEF, 1'b0, 1'b1);
      chk("sat_hold", W'(drop_cnt), W'(255));

      // Async reset mid-stream while FULL
      step(1'b1, 32'hC0, 1'b0, 1'b0);
      step(1'b1, 32'hC1, 1'b0, 1'b0);
      chk("pre_rst_full", W'(occupancy), W'(2));
      #3;
      reset = 1'b0;
      #1;
      chk_reset_vals("async");
      sbq.delete();
      mdrop = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      #1;
      chk("rel2_in_ready_low", W'(bus.in_ready), '0);
      @(posedge clk);
      #1;
      chk("rel2_in_ready", W'(bus.in_ready), W'(1));

      // Resume streaming after reset
      for (int i = 0; i < 4; i++) step(1'b1, W'(32'hD0 + i), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
